// File: rtl/rv32i_id_pipe.sv
// RV32I decode/operand stage between IF and EX.
// Resolves rs1/rs2 through a priority forwarding network, detects load-use
// hazards (one bubble), resolves branches and jumps, squashes a configurable
// number of wrong-path instructions after a redirect, and parks in a sticky
// HALT state on EBREAK/ECALL until reset.
module rv32i_id_pipe #(
    parameter int          XLEN         = 32,
    parameter int          NUM_FWD      = 3,
    parameter int          FLUSH_CYCLES = 1,
    parameter logic [31:0] NOP_IW       = 32'h00000013
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [31:0]             iw_in,
    input  logic [31:0]             pc_in,
    input  logic                    valid_in,
    input  logic [XLEN-1:0]         rs1_data_in,
    input  logic [XLEN-1:0]         rs2_data_in,
    input  logic [NUM_FWD-1:0]      df_enable,
    input  logic [5*NUM_FWD-1:0]    df_reg,
    input  logic [XLEN*NUM_FWD-1:0] df_data,
    input  logic                    ex_is_load,
    output logic [4:0]              rs1_reg,
    output logic [4:0]              rs2_reg,
    output logic                    stall_out,
    output logic                    jump_enable,
    output logic [31:0]             jump_addr,
    output logic [31:0]             iw_out,
    output logic [31:0]             pc_out,
    output logic [XLEN-1:0]         rs1_data_out,
    output logic [XLEN-1:0]         rs2_data_out,
    output logic [4:0]              wb_reg,
    output logic                    wb_en_out,
    output logic                    valid_out,
    output logic                    halted
);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [31:0] IW_EBREAK = 32'h00100073;
    localparam logic [31:0] IW_ECALL  = 32'h00000073;

    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES);

    // Branch comparison; signed and unsigned views of the same operands.
    function automatic logic branch_cond(input logic [2:0]             f3,
                                         input logic signed [XLEN-1:0] a,
                                         input logic signed [XLEN-1:0] b);
        logic r;
        case (f3)
            3'b000:  r = (a == b);
            3'b001:  r = (a != b);
            3'b100:  r = (a < b);
            3'b101:  r = (a >= b);
            3'b110:  r = ($unsigned(a) < $unsigned(b));
            3'b111:  r = ($unsigned(a) >= $unsigned(b));
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    logic [1:0]             state;
    logic [2:0]             flush_cnt;

    logic [6:0]             opcode;
    logic [2:0]             funct3;
    logic [4:0]             rd;
    logic signed [XLEN-1:0] rs1_int;
    logic signed [XLEN-1:0] rs2_int;
    logic [31:0]            imm_i;
    logic [31:0]            imm_b;
    logic [31:0]            imm_j;
    logic                   uses_rs1;
    logic                   uses_rs2;
    logic                   hazard;
    logic                   halt_iw;
    logic                   issue;
    logic                   halt_req;
    logic                   taken;
    logic [31:0]            target;
    logic                   dec_wb_en;

    logic [31:0]            iw_p1;
    logic [31:0]            pc_p1;
    logic [XLEN-1:0]        rs1_p1;
    logic [XLEN-1:0]        rs2_p1;
    logic [4:0]             wb_reg_p1;
    logic                   wb_en_p1;
    logic                   vld_p1;
    logic                   halted_p1;

    assign opcode  = iw_in[6:0];
    assign funct3  = iw_in[14:12];
    assign rd      = iw_in[11:7];
    assign rs1_reg = iw_in[19:15];
    assign rs2_reg = iw_in[24:20];

    assign imm_i = {{20{iw_in[31]}}, iw_in[31:20]};
    assign imm_b = {{19{iw_in[31]}}, iw_in[31], iw_in[7], iw_in[30:25], iw_in[11:8], 1'b0};
    assign imm_j = {{11{iw_in[31]}}, iw_in[31], iw_in[19:12], iw_in[20], iw_in[30:21], 1'b0};

    // Operand forwarding: walk from oldest to youngest so the lowest index wins.
    always_comb begin
        rs1_int = rs1_data_in;
        rs2_int = rs2_data_in;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (df_enable[i] && (df_reg[5*i +: 5] == rs1_reg) && (rs1_reg != 5'd0))
                rs1_int = df_data[XLEN*i +: XLEN];
            if (df_enable[i] && (df_reg[5*i +: 5] == rs2_reg) && (rs2_reg != 5'd0))
                rs2_int = df_data[XLEN*i +: XLEN];
        end
    end

    assign uses_rs1 = !((opcode == OP_LUI) || (opcode == OP_AUIPC) || (opcode == OP_JAL));
    assign uses_rs2 = (opcode == OP_BRANCH) || (opcode == OP_STORE) || (opcode == OP_OP);

    // A load in EX cannot forward yet; hold the consumer for one cycle.
    assign hazard = (state == ST_RUN) && valid_in && ex_is_load && df_enable[0] &&
                    (df_reg[4:0] != 5'd0) &&
                    ((uses_rs1 && (df_reg[4:0] == rs1_reg)) ||
                     (uses_rs2 && (df_reg[4:0] == rs2_reg)));

    assign halt_iw  = (iw_in == IW_EBREAK) || (iw_in == IW_ECALL);
    assign issue    = (state == ST_RUN) && valid_in && !hazard && !halt_iw;
    assign halt_req = (state == ST_RUN) && valid_in && !hazard && halt_iw;

    // Jump/branch resolution; all address arithmetic wraps at 32 bits.
    always_comb begin
        taken  = 1'b0;
        target = pc_in;
        case (opcode)
            OP_JAL: begin
                taken  = 1'b1;
                target = pc_in + imm_j;
            end
            OP_JALR: begin
                taken  = 1'b1;
                target = (rs1_int[31:0] + imm_i) & ~32'd1;
            end
            OP_BRANCH: begin
                taken  = branch_cond(funct3, rs1_int, rs2_int);
                target = pc_in + imm_b;
            end
            default: begin
                taken  = 1'b0;
                target = pc_in;
            end
        endcase
    end

    assign jump_enable = issue && taken;
    assign jump_addr   = jump_enable ? target : pc_in;
    assign stall_out   = hazard || (state == ST_HALT);

    assign dec_wb_en = !((opcode == OP_BRANCH) || (opcode == OP_STORE) ||
                         (opcode == OP_FENCE)  || (opcode == OP_SYSTEM)) && (rd != 5'd0);

    // ID/EX register and stage control (RUN/FLUSH/HALT, squash counter).
    always_ff @(posedge clk) begin
        if (reset) begin
            iw_p1     <= NOP_IW;
            pc_p1     <= 32'd0;
            rs1_p1    <= '0;
            rs2_p1    <= '0;
            wb_reg_p1 <= 5'd0;
            wb_en_p1  <= 1'b0;
            vld_p1    <= 1'b0;
            halted_p1 <= 1'b0;
            state     <= ST_RUN;
            flush_cnt <= 3'd0;
        end else begin
            // ---- ID -> EX boundary ----
            pc_p1     <= pc_in;
            rs1_p1    <= rs1_int;
            rs2_p1    <= rs2_int;
            wb_reg_p1 <= rd;
            iw_p1     <= issue ? iw_in : NOP_IW;
            wb_en_p1  <= issue && dec_wb_en;
            vld_p1    <= issue;
            case (state)
                ST_RUN: begin
                    if (halt_req) begin
                        state     <= ST_HALT;
                        halted_p1 <= 1'b1;
                    end else if (jump_enable) begin
                        state     <= ST_FLUSH;
                        flush_cnt <= FLUSH_INIT;
                    end
                end
                ST_FLUSH: begin
                    flush_cnt <= flush_cnt - 3'd1;
                    if (flush_cnt <= 3'd1)
                        state <= ST_RUN;
                end
                ST_HALT: begin
                    halted_p1 <= 1'b1;
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

    assign iw_out       = iw_p1;
    assign pc_out       = pc_p1;
    assign rs1_data_out = rs1_p1;
    assign rs2_data_out = rs2_p1;
    assign wb_reg       = wb_reg_p1;
    assign wb_en_out    = wb_en_p1;
    assign valid_out    = vld_p1;
    assign halted       = halted_p1;

endmodule

// File: tb/tb_rv32i_id_pipe.sv
// Scoreboard bench for rv32i_id_pipe: a driver applies directed vectors and
// pushes the expected ID/EX register contents; a monitor pops and compares
// one entry after every clock edge.
module tb_rv32i_id_pipe;

    localparam logic [31:0] NOP     = 32'h00000013;
    localparam logic [31:0] ADD156  = 32'h006280B3; // add x1,x5,x6
    localparam logic [31:0] ADD106  = 32'h006000B3; // add x1,x0,x6
    localparam logic [31:0] ADD432  = 32'h00218233; // add x4,x3,x2
    localparam logic [31:0] LUI4    = 32'h00018237; // lui x4 (rs1 field = 3)
    localparam logic [31:0] BEQ12   = 32'hFE208CE3; // beq x1,x2,-8
    localparam logic [31:0] JALR12  = 32'h007100E7; // jalr x1,7(x2)
    localparam logic [31:0] JAL0    = 32'h0080006F; // jal x0,+8
    localparam logic [31:0] EBREAK  = 32'h00100073;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] iw_in, pc_in;
    logic        valid_in;
    logic [31:0] rs1_data_in, rs2_data_in;
    logic [2:0]  df_enable;
    logic [14:0] df_reg;
    logic [95:0] df_data;
    logic        ex_is_load;
    logic [4:0]  rs1_reg, rs2_reg;
    logic        stall_out, jump_enable;
    logic [31:0] jump_addr, iw_out, pc_out, rs1_data_out, rs2_data_out;
    logic [4:0]  wb_reg;
    logic        wb_en_out, valid_out, halted;

    rv32i_id_pipe #(.XLEN(32), .NUM_FWD(3), .FLUSH_CYCLES(2), .NOP_IW(NOP)) dut (
        .clk(clk), .reset(reset), .iw_in(iw_in), .pc_in(pc_in), .valid_in(valid_in),
        .rs1_data_in(rs1_data_in), .rs2_data_in(rs2_data_in),
        .df_enable(df_enable), .df_reg(df_reg), .df_data(df_data), .ex_is_load(ex_is_load),
        .rs1_reg(rs1_reg), .rs2_reg(rs2_reg), .stall_out(stall_out),
        .jump_enable(jump_enable), .jump_addr(jump_addr),
        .iw_out(iw_out), .pc_out(pc_out), .rs1_data_out(rs1_data_out),
        .rs2_data_out(rs2_data_out), .wb_reg(wb_reg), .wb_en_out(wb_en_out),
        .valid_out(valid_out), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] iw, pc, rs1, rs2;
        logic [4:0]  wbr;
        logic        wben, valid, hlt, chk_data;
        int          tag;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   tag      = 0;

    task automatic chk(input string nm, input int t, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s tag=%0d got=%h want=%h", nm, t, act, want);
        end
    endtask

    function automatic exp_t e_issue(input logic [31:0] iw, input logic [31:0] pc,
                                     input logic [31:0] r1, input logic [31:0] r2,
                                     input logic wben);
        exp_t e;
        e.iw = iw; e.pc = pc; e.rs1 = r1; e.rs2 = r2; e.wbr = iw[11:7];
        e.wben = wben; e.valid = 1'b1; e.hlt = 1'b0; e.chk_data = 1'b1; e.tag = 0;
        return e;
    endfunction

    function automatic exp_t e_bubble(input logic hlt);
        exp_t e;
        e.iw = NOP; e.pc = 32'd0; e.rs1 = 32'd0; e.rs2 = 32'd0; e.wbr = 5'd0;
        e.wben = 1'b0; e.valid = 1'b0; e.hlt = hlt; e.chk_data = 1'b0; e.tag = 0;
        return e;
    endfunction

    function automatic exp_t e_reset();
        exp_t e;
        e = e_bubble(1'b0);
        e.chk_data = 1'b1;
        return e;
    endfunction

    // Monitor: compare registered outputs just after each active edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("iw_out",    e.tag, iw_out,           e.iw);
            chk("valid_out", e.tag, 32'(valid_out),   32'(e.valid));
            chk("wb_en_out", e.tag, 32'(wb_en_out),   32'(e.wben));
            chk("halted",    e.tag, 32'(halted),      32'(e.hlt));
            if (e.chk_data) begin
                chk("pc_out",       e.tag, pc_out,       e.pc);
                chk("rs1_data_out", e.tag, rs1_data_out, e.rs1);
                chk("rs2_data_out", e.tag, rs2_data_out, e.rs2);
                chk("wb_reg",       e.tag, 32'(wb_reg),  32'(e.wbr));
            end
        end
    end

    task automatic drive(input logic [31:0] iw, input logic [31:0] pc, input logic v,
                         input logic [31:0] r1, input logic [31:0] r2);
        iw_in = iw; pc_in = pc; valid_in = v; rs1_data_in = r1; rs2_data_in = r2;
        #1;
    endtask

    task automatic comb(input logic st, input logic je, input logic [31:0] ja);
        chk("stall_out",   tag, 32'(stall_out),   32'(st));
        chk("jump_enable", tag, 32'(jump_enable), 32'(je));
        chk("jump_addr",   tag, jump_addr,        ja);
    endtask

    task automatic step(input exp_t e);
        e.tag = tag;
        exp_q.push_back(e);
        @(posedge clk);
        #2;
        tag++;
    endtask

    initial begin
        reset = 1'b1; ex_is_load = 1'b0;
        df_enable = 3'b000; df_reg = '0; df_data = '0;
        drive(NOP, 32'd0, 1'b0, 32'd0, 32'd0);
        step(e_reset());
        step(e_reset());
        reset = 1'b0;

        // Forwarding priority
        df_enable = 3'b111; df_reg = {5'd5, 5'd5, 5'd5};
        df_data = {32'h0000000C, 32'h0000000B, 32'h0000000A};
        drive(ADD156, 32'h10, 1'b1, 32'h55, 32'h66);
        chk("rs1_reg", tag, 32'(rs1_reg), 32'd5);
        chk("rs2_reg", tag, 32'(rs2_reg), 32'd6);
        comb(1'b0, 1'b0, 32'h10);
        step(e_issue(ADD156, 32'h10, 32'hA, 32'h66, 1'b1));
        df_enable = 3'b110;
        drive(ADD156, 32'h14, 1'b1, 32'h55, 32'h66);
        step(e_issue(ADD156, 32'h14, 32'hB, 32'h66, 1'b1));
        df_enable = 3'b111; df_reg = '0;
        drive(ADD106, 32'h18, 1'b1, 32'h55, 32'h66);
        step(e_issue(ADD106, 32'h18, 32'h55, 32'h66, 1'b1));

        // Load-use hazard: one bubble, then reissue with source-1 data
        ex_is_load = 1'b1; df_enable = 3'b001; df_reg = {5'd0, 5'd0, 5'd3};
        df_data = {32'h0, 32'h0, 32'h0000DEAD};
        drive(ADD432, 32'h20, 1'b1, 32'h33, 32'h22);
        comb(1'b1, 1'b0, 32'h20);
        step(e_bubble(1'b0));
        ex_is_load = 1'b0; df_enable = 3'b010; df_reg = {5'd0, 5'd3, 5'd3};
        df_data = {32'h0, 32'h00001234, 32'h0};
        drive(ADD432, 32'h20, 1'b1, 32'h33, 32'h22);
        comb(1'b0, 1'b0, 32'h20);
        step(e_issue(ADD432, 32'h20, 32'h1234, 32'h22, 1'b1));
        // LUI does not read rs1: no stall, forwarding still resolves the field
        ex_is_load = 1'b1; df_enable = 3'b001; df_reg = {5'd0, 5'd0, 5'd3};
        df_data = {32'h0, 32'h0, 32'h0000DEAD};
        drive(LUI4, 32'h24, 1'b1, 32'h33, 32'h22);
        comb(1'b0, 1'b0, 32'h24);
        step(e_issue(LUI4, 32'h24, 32'hDEAD, 32'h22, 1'b1));
        ex_is_load = 1'b0; df_enable = 3'b000; df_reg = '0; df_data = '0;

        // Taken branch, two squashed slots, then normal issue
        drive(BEQ12, 32'h100, 1'b1, 32'h5, 32'h5);
        comb(1'b0, 1'b1, 32'hF8);
        step(e_issue(BEQ12, 32'h100, 32'h5, 32'h5, 1'b0));
        drive(ADD156, 32'h104, 1'b1, 32'h55, 32'h66);
        comb(1'b0, 1'b0, 32'h104);
        step(e_bubble(1'b0));
        drive(ADD156, 32'h108, 1'b1, 32'h55, 32'h66);
        step(e_bubble(1'b0));
        drive(ADD156, 32'h10C, 1'b1, 32'h55, 32'h66);
        step(e_issue(ADD156, 32'h10C, 32'h55, 32'h66, 1'b1));
        drive(BEQ12, 32'h100, 1'b1, 32'h5, 32'h6);
        comb(1'b0, 1'b0, 32'h100);
        step(e_issue(BEQ12, 32'h100, 32'h5, 32'h6, 1'b0));

        // JALR / JAL
        drive(JALR12, 32'h200, 1'b1, 32'h1000, 32'h77);
        comb(1'b0, 1'b1, 32'h1006);
        step(e_issue(JALR12, 32'h200, 32'h1000, 32'h77, 1'b1));
        drive(ADD156, 32'h204, 1'b0, 32'h55, 32'h66);
        step(e_bubble(1'b0));
        drive(JAL0, 32'h300, 1'b1, 32'h0, 32'h0);
        comb(1'b0, 1'b0, 32'h300);
        step(e_bubble(1'b0));
        drive(JAL0, 32'h300, 1'b1, 32'h0, 32'h0);
        comb(1'b0, 1'b1, 32'h308);
        step(e_issue(JAL0, 32'h300, 32'h0, 32'h0, 1'b0));

        // Reset in the middle of a flush
        drive(ADD156, 32'h304, 1'b1, 32'h55, 32'h66);
        step(e_bubble(1'b0));
        reset = 1'b1;
        drive(ADD156, 32'h308, 1'b1, 32'h55, 32'h66);
        step(e_reset());
        reset = 1'b0;
        drive(ADD156, 32'h40, 1'b1, 32'h55, 32'h66);
        comb(1'b0, 1'b0, 32'h40);
        step(e_issue(ADD156, 32'h40, 32'h55, 32'h66, 1'b1));

        // EBREAK: sticky halt until reset
        drive(EBREAK, 32'h44, 1'b1, 32'h0, 32'h0);
        comb(1'b0, 1'b0, 32'h44);
        step(e_bubble(1'b1));
        for (int k = 0; k < 10; k++) begin
            ex_is_load = 1'($urandom_range(0, 1));
            df_enable  = 3'($urandom_range(0, 7));
            df_reg     = 15'($urandom);
            if (k % 3 == 0)
                drive(BEQ12, $urandom, 1'b1, 32'h9, 32'h9);
            else
                drive($urandom, $urandom, 1'b1, $urandom, $urandom);
            comb(1'b1, 1'b0, pc_in);
            step(e_bubble(1'b1));
        end
        ex_is_load = 1'b0; df_enable = 3'b000; df_reg = '0;
        reset = 1'b1;
        drive(ADD156, 32'h48, 1'b1, 32'h55, 32'h66);
        step(e_reset());
        reset = 1'b0;
        drive(ADD156, 32'h50, 1'b1, 32'h55, 32'h66);
        comb(1'b0, 1'b0, 32'h50);
        step(e_issue(ADD156, 32'h50, 32'h55, 32'h66, 1'b1));
        drive(NOP, 32'h54, 1'b0, 32'h0, 32'h0);
        step(e_bubble(1'b0));

        // Drain the scoreboard with a bounded wait
        for (int k = 0; k < 5 && exp_q.size() != 0; k++) @(posedge clk);
        #2;
        chk("scoreboard_drained", tag, 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rv32i_id_pipe.md
Name: rv32i_id_pipe

Overview:
- Parametrised next-generation RV32I decode/operand stage, sitting between IF and EX.
- Provides N-source priority forwarding, load-use hazard detection with a one-cycle bubble, branch/jump resolution, and a multi-cycle wrong-path squash counter.
- EBREAK/ECALL moves the stage into a sticky halt state.
- Drives the register-file read addresses and the registered ID/EX pipeline outputs.

Parameters:
XLEN, 32, data width of operands and forwarded values
NUM_FWD, 3, forwarding sources; index 0 = youngest (EX), highest priority
FLUSH_CYCLES, 1, incoming instructions squashed after a redirect (1..7)
NOP_IW, 32'h00000013, bubble instruction word

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
iw_in  in  32  instruction word from IF
pc_in  in  32  PC of iw_in
valid_in  in  1  iw_in is a real instruction
rs1_data_in  in  XLEN  register-file read data for rs1
rs2_data_in  in  XLEN  register-file read data for rs2
df_enable  in  NUM_FWD  per-source writeback enable
df_reg  in  5*NUM_FWD  per-source destination register, source i at [5i+4:5i]
df_data  in  XLEN*NUM_FWD  per-source writeback data
ex_is_load  in  1  instruction in EX (source 0) is a load
rs1_reg  out  5  iw_in[19:15], combinational
rs2_reg  out  5  iw_in[24:20], combinational
stall_out  out  1  combinational; IF must hold PC and iw_in
jump_enable  out  1  combinational redirect request to IF
jump_addr  out  32  combinational redirect target
iw_out  out  32  registered instruction word to EX
pc_out  out  32  registered PC
rs1_data_out  out  XLEN  registered resolved operand
rs2_data_out  out  XLEN  registered resolved operand
wb_reg  out  5  registered iw[11:7]
wb_en_out  out  1  registered writeback enable
valid_out  out  1  registered; 0 for bubbles
halted  out  1  registered; 1 in HALT

Behaviour:
- Reset values on any edge with reset=1, overriding everything, including mid-flush or halted:
  - iw_out=NOP_IW; pc_out, rs*_data_out, wb_reg = 0; wb_en_out=0; valid_out=0; halted=0.
  - state=RUN; flush counter=0.
- Forwarding:
  - rsX_int = df_data[i] for the lowest i with df_enable[i]=1, df_reg[i]==rsX_reg and rsX_reg!=0.
  - Otherwise rsX_int = rsX_data_in. x0 always resolves to rsX_data_in.
- Register usage:
  - rs1 used by every opcode except LUI (0110111), AUIPC (0010111) and JAL (1101111).
  - rs2 used only by BRANCH (1100011), STORE (0100011) and OP (0110011).
- hazard = state RUN, valid_in, ex_is_load, df_enable[0], df_reg[0]!=0, and df_reg[0] equals a used rsX_reg.
  - hazard drives stall_out=1 and inserts one bubble at the next edge.
  - The same iw_in is re-decoded next cycle, when the load has moved to source 1.
- Bubble: iw_out=NOP_IW, wb_en_out=0, valid_out=0. pc_out and data outputs still load their input values (don't-care).
- States:
  - RUN:
    - valid_in=0 -> bubble.
    - hazard -> bubble; jump_enable forced 0.
    - EBREAK (32'h00100073) or ECALL (32'h00000073) -> bubble, go to HALT.
    - Taken jump -> instruction passes to EX, jump_enable=1, counter=FLUSH_CYCLES, go to FLUSH.
    - Otherwise pass the instruction and operands through.
  - FLUSH:
    - Every incoming instruction becomes a bubble; hazard and jump are ignored.
    - Counter decrements each cycle; go to RUN on the edge where it reaches 0.
  - HALT: stall_out=1, jump_enable=0, bubbles every cycle, halted=1; leaves only via reset.
- Jump resolution:
  - JALR: target (rs1_int + sext(imm_i)) & ~1.
  - JAL: target pc_in + sext(imm_j).
  - Branch: target pc_in + sext(imm_b); funct3 000 EQ, 001 NE, 100 LT signed, 101 GE signed, 110 LTU, 111 GEU.
  - Branch funct3 010/011: not taken.
  - All address arithmetic is mod 2^32. jump_addr = pc_in when jump_enable=0.
- wb_en_out = 0 for BRANCH, STORE, FENCE (0001111), SYSTEM (1110011), bubbles, or rd==0; otherwise 1.
  - JAL/JALR with rd!=0 get wb_en_out=1; EX writes pc+4.
- Precedence: reset > HALT > FLUSH > hazard > EBREAK/ECALL > jump > normal.

Test Plan:
- Forward priority: NUM_FWD=3, x5 matched by sources 0 (0xA), 1 (0xB), 2 (0xC), all enabled, ADD x1,x5,x6 -> rs1_data_out=0xA; disable source 0 -> 0xB; rs1=x0 with matching source -> regfile value.
- Load-use: LW x3 in EX (ex_is_load=1, df_reg[0]=3), ADD x4,x3,x2 at ID -> stall_out=1 one cycle, one bubble (valid_out=0), then ADD issued with df_data[1] as rs1; LUI x4 in the same slot -> no stall.
- Branch: BEQ pc=0x100, imm=-8, operands equal -> jump_enable=1, jump_addr=0xF8; with FLUSH_CYCLES=2 the next two valid inputs become bubbles, the third issues; operands unequal -> no jump.
- JALR x1, 7(x2), x2=0x1000 -> jump_addr=0x1006, wb_en_out=1 next cycle; JAL x0 -> wb_en_out=0.
- EBREAK at ID -> next edge iw_out=0x13, halted=1, stall_out=1 held 10 cycles with arbitrary inputs; reset=1 -> halted=0, state RUN next edge.
- Reset during FLUSH (counter=1) -> next edge all outputs at reset values, instruction after reset issues normally.
